// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: core input word width, byte-lane count and the
// word record carried between the byte packer and the core input stage.
package sm3_pkg;

`ifdef SM3_INPT_DW_64
    localparam int SM3_INPT_DW = 64;
`else
    localparam int SM3_INPT_DW = 32;
`endif

    localparam int SM3_INPT_BW = SM3_INPT_DW / 8;
    localparam int SM3_CNT_W   = $clog2(SM3_INPT_BW);

    // One core input word: big-endian data, lane-valid mask (MSB lane first)
    // and the end-of-message marker.
    typedef struct packed {
        logic [SM3_INPT_DW-1:0] data;
        logic [SM3_INPT_BW-1:0] mask;
        logic                   lst;
    } sm3_word_t;

endpackage

// File: rtl/sm3_byte_packer_if.sv
// Byte-stream input and core word-output handshakes of the SM3 byte packer.
// The master modport is the packer's view (it masters the core word bus);
// the slave modport is the surrounding environment's view.
interface sm3_byte_packer_if;
    import sm3_pkg::*;

    logic [7:0]             s_byte;
    logic                   s_vld;
    logic                   s_lst;
    logic                   s_rdy;

    logic [SM3_INPT_DW-1:0] msg_inpt_d;
    logic [SM3_INPT_BW-1:0] msg_inpt_vld_byte;
    logic                   msg_inpt_vld;
    logic                   msg_inpt_lst;
    logic                   msg_inpt_rdy;

    modport master (
        input  s_byte, s_vld, s_lst, msg_inpt_rdy,
        output s_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
    );

    modport slave (
        output s_byte, s_vld, s_lst, msg_inpt_rdy,
        input  s_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
    );
endinterface

// File: rtl/sm3_word_reg.sv
// Valid/ready holding register for one sm3_word_t. Accepts a word whenever
// it is empty or its content is leaving this cycle, and holds the word
// stable while the consumer stalls.
module sm3_word_reg
    import sm3_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_vld,
    input  sm3_word_t i_word,
    output logic      o_rdy,
    output logic      o_vld,
    output sm3_word_t o_word,
    input  logic      i_rdy
);

    logic      r_vld;
    sm3_word_t r_word;
    logic      w_load;

    assign o_rdy  = !r_vld || i_rdy;
    assign w_load = i_vld && o_rdy;
    assign o_vld  = r_vld;
    assign o_word = r_word;

    // Load on accept, drop valid after a transfer that is not refilled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_word <= '0;
        end else if (w_load) begin
            r_vld  <= 1'b1;
            r_word <= i_word;
        end else if (i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/sm3_byte_packer.sv
// Byte-serial to word packer feeding the SM3 core input. Bytes are packed
// big-endian into an accumulator; completed words move into an output
// holding register, so one byte per cycle is sustained while the core
// applies backpressure to a single pending word.
module sm3_byte_packer
    import sm3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    sm3_byte_packer_if.master pk,
    output logic              busy
);

    localparam int DW = SM3_INPT_DW;
    localparam int BW = SM3_INPT_BW;
    localparam int CW = SM3_CNT_W;

    logic [CW-1:0]         r_cnt;
    sm3_word_t             r_acc;
    logic                  r_acc_done;

    logic                  w_out_rdy;
    logic                  w_out_vld;
    sm3_word_t             w_out_word;
    logic                  w_out_load;
    logic                  w_s_rdy;
    logic                  w_accept;
    logic                  w_complete;
    logic [CW-1:0]         w_lane;
    logic [$clog2(DW)-1:0] w_bit_lo;
    sm3_word_t             w_acc_nxt;

    // A finished accumulator word may only move when the output register frees.
    assign w_out_load = r_acc_done && w_out_rdy;
    // Input is open while the accumulator is filling or is being emptied now.
    assign w_s_rdy    = !r_acc_done || w_out_load;
    assign w_accept   = pk.s_vld && w_s_rdy;
    assign w_complete = w_accept && ((r_cnt == CW'(BW - 1)) || pk.s_lst);
    // First byte of each word goes to the most significant lane.
    assign w_lane     = CW'(BW - 1) - r_cnt;
    assign w_bit_lo   = {w_lane, 3'b000};

    // Next accumulator content: clear after a move, then merge the new byte.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_out_load) begin
            w_acc_nxt = '0;
        end
        if (w_accept) begin
            w_acc_nxt.data[w_bit_lo +: 8] = pk.s_byte;
            w_acc_nxt.mask[w_lane]        = 1'b1;
            w_acc_nxt.lst                 = pk.s_lst;
        end
    end

    // Accumulator, lane counter and word-complete flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_acc_done <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            if (w_complete) begin
                r_acc_done <= 1'b1;
                r_cnt      <= '0;
            end else begin
                if (w_out_load) begin
                    r_acc_done <= 1'b0;
                end
                if (w_accept) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    sm3_word_reg u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (r_acc_done),
        .i_word (r_acc),
        .o_rdy  (w_out_rdy),
        .o_vld  (w_out_vld),
        .o_word (w_out_word),
        .i_rdy  (pk.msg_inpt_rdy)
    );

    assign pk.s_rdy             = w_s_rdy;
    assign pk.msg_inpt_d        = w_out_word.data;
    assign pk.msg_inpt_vld_byte = w_out_word.mask;
    assign pk.msg_inpt_lst      = w_out_word.lst;
    assign pk.msg_inpt_vld      = w_out_vld;

    assign busy = (r_cnt != '0) || r_acc_done || w_out_vld;

endmodule

// File: tb/tb_sm3_byte_packer.sv
// Testbench for sm3_byte_packer: directed scenarios plus randomized messages,
// compared against a message-level packing model.
module tb_sm3_byte_packer;
    import sm3_pkg::*;

    localparam int DW         = SM3_INPT_DW;
    localparam int BW         = SM3_INPT_BW;
    localparam int CMPW       = 128;
    localparam int WAIT_LIMIT = 500;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    sm3_byte_packer_if bus ();

    sm3_byte_packer dut (
        .clk  (clk),
        .rst  (rst),
        .pk   (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        hold_viol = 0;
    int        last_acc_cyc = 0;
    int        rd_ptr = 0;
    logic      rand_rdy = 1'b0;
    logic      prev_stall = 1'b0;
    sm3_word_t prev_word;
    sm3_word_t mon_word;
    sm3_word_t got_q[$];
    int        got_cyc[$];
    sm3_word_t exp_q[$];

    assign mon_word = {bus.msg_inpt_d, bus.msg_inpt_vld_byte, bus.msg_inpt_lst};

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records transferred words and flags unstable stalled words.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!bus.msg_inpt_vld || mon_word !== prev_word))
                hold_viol <= hold_viol + 1;
            if (bus.msg_inpt_vld && bus.msg_inpt_rdy) begin
                got_q.push_back(mon_word);
                got_cyc.push_back(cyc);
            end
            prev_stall <= bus.msg_inpt_vld && !bus.msg_inpt_rdy;
            prev_word  <= mon_word;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [CMPW-1:0] obs, input logic [CMPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.msg_inpt_rdy = 1'($urandom_range(0, 1));
    endtask

    // Reference packing: chunk the message into BW-byte groups, first byte
    // most significant, short tail left-aligned with a left-aligned mask.
    task automatic model_msg(input logic [7:0] m[$]);
        for (int base = 0; base < m.size(); base += BW) begin
            sm3_word_t w;
            int k;
            k = (m.size() - base < BW) ? (m.size() - base) : BW;
            w.data = '0;
            for (int j = 0; j < k; j++) w.data = (w.data << 8) | DW'(m[base + j]);
            w.data = w.data << (8 * (BW - k));
            w.mask = ~({BW{1'b1}} >> k);
            w.lst  = (base + BW >= m.size());
            exp_q.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, output int waited);
        bus.s_byte = b;
        bus.s_vld  = 1'b1;
        bus.s_lst  = l;
        waited = 0;
        @(negedge clk);
        while (!bus.s_rdy && waited < WAIT_LIMIT) begin
            waited++;
            tick();
            @(negedge clk);
        end
        chk("send_accept", CMPW'(waited < WAIT_LIMIT), CMPW'(1));
        last_acc_cyc = cyc;
        tick();
        bus.s_vld = 1'b0;
        bus.s_lst = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] m[$], input int gap_max, output int total_wait);
        int w;
        model_msg(m);
        total_wait = 0;
        for (int i = 0; i < m.size(); i++) begin
            send_byte(m[i], (i == m.size() - 1), w);
            total_wait += w;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic drain_check(input string tag);
        int w;
        w = 0;
        while (got_q.size() < rd_ptr + exp_q.size() && w < WAIT_LIMIT) begin
            tick();
            w++;
        end
        repeat (3) tick();
        chk({tag, "_count"}, CMPW'(got_q.size() - rd_ptr), CMPW'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (rd_ptr + k < got_q.size())
                chk(tag, CMPW'(got_q[rd_ptr + k]), CMPW'(exp_q[k]));
        rd_ptr = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] m[$];
        int         tw;
        int         nacc;
        int         first_idx;
        logic       acc;

        bus.s_byte       = 8'h00;
        bus.s_vld        = 1'b0;
        bus.s_lst        = 1'b0;
        bus.msg_inpt_rdy = 1'b1;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, first cycle after reset release.
        @(negedge clk);
        chk("rst_d",     CMPW'(bus.msg_inpt_d),        CMPW'(0));
        chk("rst_mask",  CMPW'(bus.msg_inpt_vld_byte), CMPW'(0));
        chk("rst_vld",   CMPW'(bus.msg_inpt_vld),      CMPW'(0));
        chk("rst_lst",   CMPW'(bus.msg_inpt_lst),      CMPW'(0));
        chk("rst_busy",  CMPW'(busy),                  CMPW'(0));
        chk("rst_s_rdy", CMPW'(bus.s_rdy),             CMPW'(1));
        tick();

        // "abc": partial last word.
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0, tw);
        drain_check("abc");
        chk("abc_latency", CMPW'((got_cyc[got_cyc.size() - 1] - last_acc_cyc) <= 2), CMPW'(1));
        @(negedge clk);
        chk("abc_idle_busy", CMPW'(busy), CMPW'(0));
        tick();

        // "abcd" then a one-byte message starting again at the top lane.
        m = '{8'h61, 8'h62, 8'h63, 8'h64};
        send_msg(m, 0, tw);
        m = '{8'h65};
        send_msg(m, 0, tw);
        drain_check("abcd_next");

        // Backpressure: core stalls 20 cycles while 3 words of bytes stream in.
        m.delete();
        for (int i = 0; i < 3 * BW; i++) m.push_back(8'(i));
        model_msg(m);
        bus.msg_inpt_rdy = 1'b0;
        nacc = 0;
        for (int c = 0; c < 400 && nacc < 3 * BW; c++) begin
            if (c == 20) bus.msg_inpt_rdy = 1'b1;
            bus.s_byte = 8'(nacc);
            bus.s_vld  = 1'b1;
            bus.s_lst  = (nacc == 3 * BW - 1);
            @(negedge clk);
            if (c == 19) begin
                chk("bp_accepted", CMPW'(nacc),            CMPW'(2 * BW));
                chk("bp_s_rdy",    CMPW'(bus.s_rdy),       CMPW'(0));
                chk("bp_vld",      CMPW'(bus.msg_inpt_vld), CMPW'(1));
                chk("bp_hold_d",   CMPW'(bus.msg_inpt_d),  CMPW'(exp_q[0].data));
            end
            acc = bus.s_rdy;
            @(posedge clk);
            #1;
            if (acc) nacc++;
        end
        bus.s_vld = 1'b0;
        bus.s_lst = 1'b0;
        chk("bp_all_accepted", CMPW'(nacc), CMPW'(3 * BW));
        drain_check("bp");
        chk("bp_hold_stable", CMPW'(hold_viol), CMPW'(0));

        // Throughput: 8 full words back to back with the core always ready.
        m.delete();
        for (int i = 0; i < 8 * BW; i++) m.push_back(8'($urandom_range(0, 255)));
        first_idx = got_cyc.size();
        send_msg(m, 0, tw);
        chk("tp_no_stall", CMPW'(tw), CMPW'(0));
        drain_check("tp");
        if (got_cyc.size() >= first_idx + 8)
            chk("tp_spacing", CMPW'(got_cyc[first_idx + 7] - got_cyc[first_idx]), CMPW'(7 * BW));

        // Short final word.
        m = '{8'hAA, 8'hBB, 8'hCC};
        send_msg(m, 0, tw);
        drain_check("partial");

        // Reset with a stalled output word and a half-filled accumulator.
        bus.msg_inpt_rdy = 1'b0;
        for (int i = 0; i < BW + 2; i++) send_byte(8'(8'h10 + i), 1'b0, tw);
        tick();
        @(negedge clk);
        chk("pre_rst_busy", CMPW'(busy),             CMPW'(1));
        chk("pre_rst_vld",  CMPW'(bus.msg_inpt_vld), CMPW'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_d",     CMPW'(bus.msg_inpt_d),        CMPW'(0));
        chk("mid_rst_mask",  CMPW'(bus.msg_inpt_vld_byte), CMPW'(0));
        chk("mid_rst_vld",   CMPW'(bus.msg_inpt_vld),      CMPW'(0));
        chk("mid_rst_lst",   CMPW'(bus.msg_inpt_lst),      CMPW'(0));
        chk("mid_rst_busy",  CMPW'(busy),                  CMPW'(0));
        chk("mid_rst_s_rdy", CMPW'(bus.s_rdy),             CMPW'(1));
        tick();
        bus.msg_inpt_rdy = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 0, tw);
        drain_check("abc_after_rst");

        // Randomized messages with input gaps and random core backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 25; n++) begin
            m.delete();
            for (int i = 0; i < $urandom_range(1, 3 * BW); i++) m.push_back(8'($urandom_range(0, 255)));
            send_msg(m, 2, tw);
        end
        rand_rdy = 1'b0;
        bus.msg_inpt_rdy = 1'b1;
        drain_check("rand");
        chk("rand_hold_stable", CMPW'(hold_viol), CMPW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
